// File: rtl/repeated_sub_divider.sv
// Unsigned divider by repeated subtraction: a controller FSM plus a rem/dvs/quo datapath.
// Results and status are presented through one output register stage, so they lag the internal state by one cycle.
module repeated_sub_divider #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset_L,
   input  logic         start,
   input  logic [W-1:0] inputA,
   input  logic [W-1:0] inputB,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         busy,
   output logic         done,
   output logic         div_zero
);

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      SUB   = 2'd1,
      DONE  = 2'd2,
      DZERO = 2'd3
   } state_t;

   state_t         state_r, next_state_s;
   logic [W-1:0]   rem_r, dvs_r, quo_r;
   logic [W-1:0]   rem_next_s, dvs_next_s, quo_next_s;
   logic           ge_s;

   // Comparator: one more subtraction is allowed while rem >= dvs.
   always_comb begin
      ge_s = (rem_r >= dvs_r);
   end

   // Next-state and datapath control.
   always_comb begin
      next_state_s = state_r;
      rem_next_s   = rem_r;
      dvs_next_s   = dvs_r;
      quo_next_s   = quo_r;
      case (state_r)
         INIT, DONE, DZERO: begin
            if (start) begin
               rem_next_s   = inputA;
               dvs_next_s   = inputB;
               quo_next_s   = {W{1'b0}};
               next_state_s = (inputB == {W{1'b0}}) ? DZERO : SUB;
            end else begin
               next_state_s = state_r;
            end
         end
         SUB: begin
            if (ge_s) begin
               rem_next_s = rem_r - dvs_r;
               quo_next_s = quo_r + {{(W-1){1'b0}}, 1'b1};
            end else begin
               next_state_s = DONE;
            end
         end
         default: begin
            next_state_s = INIT;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_r <= INIT;
         rem_r   <= {W{1'b0}};
         dvs_r   <= {W{1'b0}};
         quo_r   <= {W{1'b0}};
      end else begin
         state_r <= next_state_s;
         rem_r   <= rem_next_s;
         dvs_r   <= dvs_next_s;
         quo_r   <= quo_next_s;
      end
   end

   // Output register stage: decoded status and results from the current state and datapath.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         quotient  <= {W{1'b0}};
         remainder <= {W{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         quotient  <= quo_r;
         remainder <= rem_r;
         busy      <= (state_r == SUB);
         done      <= (state_r == DONE) || (state_r == DZERO);
         div_zero  <= (state_r == DZERO);
      end
   end

endmodule
